// File: rtl/uart_frame_parser_if.sv
// Payload byte stream from the frame parser to the command logic.
// Valid/ready handshake with an end-of-packet marker.
interface uart_frame_parser_if #(
    parameter int data_width = 8
) ();
    logic [data_width-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_last;

    modport master (
        output o_data,
        output o_valid,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Frame parser: header pair, LEN, payload, XOR checksum.
// Good payloads are buffered and replayed on a valid/ready stream.
module uart_frame_parser #(
    parameter int                    data_width     = 8,
    parameter int                    max_payload    = 16,
    parameter logic [data_width-1:0] head0          = 8'h55,
    parameter logic [data_width-1:0] head1          = 8'hAA,
    parameter int                    timeout_cycles = 52080
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [data_width-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    uart_frame_parser_if.master   out_if,
    output logic                  o_frame_ok,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int IW = (max_payload > 1) ? $clog2(max_payload) : 1;
    localparam int TW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    localparam logic [data_width-1:0] MAXP = data_width'(max_payload);
    localparam logic [TW-1:0] TMAX = TW'(timeout_cycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD1,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_OUTPUT
    } state_t;

    state_t                state_q, state_d;
    logic [data_width-1:0] len_q, len_d;
    logic [data_width-1:0] chk_q, chk_d;
    logic [data_width-1:0] idx_q, idx_d;
    logic [data_width-1:0] rd_q, rd_d;
    logic [data_width-1:0] rd_n;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;
    logic                  busy_q, busy_d;
    logic                  wr_en;
    logic                  timed;
    logic [data_width-1:0] buf_q [max_payload];

    // Next-state, checksum, timeout and output-register logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        tmo_d   = '0;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        wr_en   = 1'b0;
        rd_n    = rd_q + 1'b1;
        timed   = (state_q == S_HEAD1) || (state_q == S_LEN) ||
                  (state_q == S_PAYLOAD) || (state_q == S_CHECK);

        // A byte in the same cycle always beats the timeout.
        if (timed && !i_rx_valid) begin
            if (tmo_q == TMAX) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_rx_valid && i_rx_data == head0)
                    state_d = S_HEAD1;
            end
            S_HEAD1: begin
                if (i_rx_valid) begin
                    if (i_rx_data == head1)
                        state_d = S_LEN;
                    else if (i_rx_data == head0)
                        state_d = S_HEAD1;
                    else
                        state_d = S_IDLE;
                end
            end
            S_LEN: begin
                if (i_rx_valid) begin
                    len_d = i_rx_data;
                    chk_d = i_rx_data;
                    if (i_rx_data == '0 || i_rx_data > MAXP) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_valid) begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ i_rx_data;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1)
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_rx_valid) begin
                    if (i_rx_data == chk_q) begin
                        ok_d    = 1'b1;
                        rd_d    = '0;
                        valid_d = 1'b1;
                        data_d  = buf_q[0];
                        last_d  = (len_q == 1);
                        state_d = S_OUTPUT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_OUTPUT: begin
                ovr_d = i_rx_valid;
                if (valid_q && out_if.i_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        rd_d   = rd_n;
                        data_d = buf_q[rd_n[IW-1:0]];
                        last_d = (rd_n == len_q - 1'b1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    // Payload buffer; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            buf_q[idx_q[IW-1:0]] <= i_rx_data;
    end

    assign out_if.o_data  = data_q;
    assign out_if.o_valid = valid_q;
    assign out_if.o_last  = last_q;
    assign o_frame_ok     = ok_q;
    assign o_frame_err    = err_q;
    assign o_overrun      = ovr_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame-level model plus directed frames.
// The model parses each injected byte list into expected pulses/payload.
module tb_uart_frame_parser;

    localparam int TMO  = 60;
    localparam int MAXP = 16;
    localparam int K_OK  = 0;
    localparam int K_ERR = 1;
    localparam int K_OVR = 2;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } pb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ready = 1'b1;
    logic       f_ok, f_err, f_ovr, f_busy;

    uart_frame_parser_if #(.data_width(8)) out_if ();
    assign out_if.i_ready = ready;

    uart_frame_parser #(
        .data_width    (8),
        .max_payload   (MAXP),
        .head0         (8'h55),
        .head1         (8'hAA),
        .timeout_cycles(TMO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .out_if     (out_if),
        .o_frame_ok (f_ok),
        .o_frame_err(f_err),
        .o_overrun  (f_ovr),
        .o_busy     (f_busy)
    );

    always #5 clk = ~clk;

    ev_t        exp_ev[$];
    pb_t        exp_pay[$];
    pb_t        seen[$];
    int         nchk = 0;
    int         nerr = 0;
    int         cyc = 0;
    logic       hs = 1'b0;
    logic       stalled = 1'b0;
    logic       out_active = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;
    int         ok_cyc = -1;
    int         err_cyc = -1;
    int         err_seen = 0;
    int         ovr_seen = 0;
    logic       e_ok, e_err, e_ovr;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_ev.push_back(e);
    endtask

    // Frame-level model: byte k of s is sampled at edge base+k.
    task automatic predict(input logic [7:0] s[$], input int base);
        int h, li, ci, n, len;
        logic [7:0] c;
        pb_t p;
        h = -1;
        n = s.size();
        for (int i = 0; i < n - 1; i++)
            if (h < 0 && s[i] == 8'h55 && s[i+1] == 8'hAA) h = i;
        if (h < 0) return;
        li = h + 2;
        if (li >= n) begin
            push_ev(base + n - 1 + TMO, K_ERR);
            return;
        end
        len = int'(s[li]);
        if (len == 0 || len > MAXP) begin
            push_ev(base + li, K_ERR);
            return;
        end
        ci = li + 1 + len;
        if (ci >= n) begin
            push_ev(base + n - 1 + TMO, K_ERR);
            return;
        end
        c = s[li];
        for (int k = 0; k < len; k++) c = c ^ s[li+1+k];
        if (s[ci] == c) begin
            push_ev(base + ci, K_OK);
            for (int k = 0; k < len; k++) begin
                p.d = s[li+1+k];
                p.l = (k == len - 1);
                exp_pay.push_back(p);
            end
        end else begin
            push_ev(base + ci, K_ERR);
        end
    endtask

    task automatic send(input logic [7:0] s[$], output int base);
        @(negedge clk);
        base = cyc + 1;
        predict(s, base);
        foreach (s[j]) begin
            rx_valid = 1'b1;
            rx_data  = s[j];
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] s[$]);
        @(negedge clk);
        foreach (s[j]) begin
            rx_valid = 1'b1;
            rx_data  = s[j];
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_ovr(input logic [7:0] b);
        @(negedge clk);
        push_ev(cyc + 1, K_OVR);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (!f_busy && !out_if.o_valid &&
                exp_ev.size() == 0 && exp_pay.size() == 0)
                done = 1'b1;
        end
        check({name, "_idle"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        hs      <= out_if.o_valid && ready;
        stalled <= out_if.o_valid && !ready;
    end

    // Compare process: every cycle against the model's expectations.
    initial forever begin
        @(negedge clk);
        if (hs) begin
            pb_t p;
            p.d = prev_d;
            p.l = prev_l;
            seen.push_back(p);
            if (exp_pay.size() > 0) begin
                if (exp_pay[0].l) out_active = 1'b0;
                void'(exp_pay.pop_front());
            end
        end
        while (exp_ev.size() > 0 && exp_ev[0].cyc < cyc)
            void'(exp_ev.pop_front());
        e_ok  = 1'b0;
        e_err = 1'b0;
        e_ovr = 1'b0;
        while (exp_ev.size() > 0 && exp_ev[0].cyc == cyc) begin
            case (exp_ev[0].kind)
                K_OK:    e_ok  = 1'b1;
                K_ERR:   e_err = 1'b1;
                default: e_ovr = 1'b1;
            endcase
            void'(exp_ev.pop_front());
        end
        if (e_ok) out_active = 1'b1;
        check("frame_ok", 32'(f_ok), 32'(e_ok));
        check("frame_err", 32'(f_err), 32'(e_err));
        check("overrun", 32'(f_ovr), 32'(e_ovr));
        check("o_valid", 32'(out_if.o_valid), 32'(out_active));
        if (out_if.o_valid && exp_pay.size() > 0) begin
            check("o_data", 32'(out_if.o_data), 32'(exp_pay[0].d));
            check("o_last", 32'(out_if.o_last), 32'(exp_pay[0].l));
        end
        if (stalled) begin
            check("hold_data", 32'(out_if.o_data), 32'(prev_d));
            check("hold_last", 32'(out_if.o_last), 32'(prev_l));
        end
        prev_d = out_if.o_data;
        prev_l = out_if.o_last;
        if (f_ok) ok_cyc = cyc;
        if (f_err) begin
            err_cyc = cyc;
            err_seen++;
        end
        if (f_ovr) ovr_seen++;
    end

    initial begin
        logic [7:0] fr[$];
        int b;
        int es;

        repeat (3) @(negedge clk);
        check("rst_data", 32'(out_if.o_data), 32'd0);
        check("rst_valid", 32'(out_if.o_valid), 32'd0);
        check("rst_last", 32'(out_if.o_last), 32'd0);
        check("rst_ok", 32'(f_ok), 32'd0);
        check("rst_err", 32'(f_err), 32'd0);
        check("rst_ovr", 32'(f_ovr), 32'd0);
        check("rst_busy", 32'(f_busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame, csum 03^11^22^33 = 03.
        seen.delete();
        fr = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send(fr, b);
        wait_idle(50, "good");
        check("good_ok_cyc", 32'(ok_cyc), 32'(b + 6));
        check("good_n", 32'(seen.size()), 32'd3);
        check("good_b0", 32'(seen[0].d), 32'h11);
        check("good_l1", 32'(seen[1].l), 32'd0);
        check("good_b2", 32'(seen[2].d), 32'h33);
        check("good_l2", 32'(seen[2].l), 32'd1);

        // Bad checksum, then a good frame (02^A5^5A = FD).
        seen.delete();
        fr = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        send(fr, b);
        wait_idle(50, "badcs");
        check("badcs_err_cyc", 32'(err_cyc), 32'(b + 6));
        check("badcs_nout", 32'(seen.size()), 32'd0);
        fr = '{8'h55, 8'hAA, 8'h02, 8'hA5, 8'h5A, 8'hFD};
        send(fr, b);
        wait_idle(50, "good2");
        check("good2_n", 32'(seen.size()), 32'd2);
        check("good2_b1", 32'(seen[1].d), 32'h5A);

        // Length limits.
        fr = '{8'h55, 8'hAA, 8'h00};
        send(fr, b);
        wait_idle(50, "len0");
        check("len0_err_cyc", 32'(err_cyc), 32'(b + 2));
        fr = '{8'h55, 8'hAA, 8'h11};
        send(fr, b);
        wait_idle(50, "len17");
        check("len17_err_cyc", 32'(err_cyc), 32'(b + 2));
        seen.delete();
        fr = '{8'h55, 8'hAA, 8'h10};
        for (int i = 0; i < 16; i++) fr.push_back(8'(i));
        fr.push_back(8'h10);
        send(fr, b);
        wait_idle(80, "len16");
        check("len16_n", 32'(seen.size()), 32'd16);
        check("len16_b15", 32'(seen[15].d), 32'h0F);
        check("len16_l15", 32'(seen[15].l), 32'd1);
        check("len16_l14", 32'(seen[14].l), 32'd0);

        // Resync on a repeated head0, then a silent abort.
        seen.delete();
        fr = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send(fr, b);
        wait_idle(50, "resync");
        check("resync_ok_cyc", 32'(ok_cyc), 32'(b + 5));
        check("resync_n", 32'(seen.size()), 32'd1);
        check("resync_b0", 32'(seen[0].d), 32'h7E);
        check("resync_l0", 32'(seen[0].l), 32'd1);
        es = err_seen;
        fr = '{8'h55, 8'h12};
        send(fr, b);
        wait_idle(50, "junk");
        check("junk_noerr", 32'(err_seen), 32'(es));

        // Inter-byte timeout.
        fr = '{8'h55, 8'hAA, 8'h02, 8'h41};
        send(fr, b);
        wait_idle(TMO + 30, "tmo");
        check("tmo_delay", 32'(err_cyc - (b + 3)), 32'(TMO));

        // Backpressure with overrun bytes (04^DE^AD^BE^EF = 26).
        seen.delete();
        ovr_seen = 0;
        ready = 1'b0;
        fr = '{8'h55, 8'hAA, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};
        send(fr, b);
        send_ovr(8'h55);
        repeat (3) @(negedge clk);
        send_ovr(8'hAA);
        repeat (12) @(negedge clk);
        ready = 1'b1;
        wait_idle(50, "stall");
        check("stall_n", 32'(seen.size()), 32'd4);
        check("stall_b0", 32'(seen[0].d), 32'hDE);
        check("stall_b3", 32'(seen[3].d), 32'hEF);
        check("stall_l3", 32'(seen[3].l), 32'd1);
        check("ovr_count", 32'(ovr_seen), 32'd2);

        // Reset mid-payload.
        seen.delete();
        fr = '{8'h55, 8'hAA, 8'h05, 8'h01, 8'h02};
        send_raw(fr);
        check("mid_busy", 32'(f_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_ev.delete();
        exp_pay.delete();
        out_active = 1'b0;
        #1;
        check("arst_valid", 32'(out_if.o_valid), 32'd0);
        check("arst_busy", 32'(f_busy), 32'd0);
        check("arst_data", 32'(out_if.o_data), 32'd0);
        check("arst_err", 32'(f_err), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        es = err_seen;
        repeat (TMO + 10) @(negedge clk);
        check("arst_noerr", 32'(err_seen), 32'(es));
        check("arst_nout", 32'(seen.size()), 32'd0);
        check("arst_idle", 32'(f_busy), 32'd0);

        // Parser still works after reset.
        fr = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send(fr, b);
        wait_idle(50, "post");
        check("post_n", 32'(seen.size()), 32'd3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
